// File: rtl/seg_scan.sv
// seg_scan -- four-digit multiplexed seven-segment scanner.
//
// The slow scan wave clk_1K is synchronised and edge-detected inside the clk
// domain; each rising edge (tick) advances to the next digit. After every
// digit change all anodes are held off for BLANK_CYC cycles to suppress
// ghosting, then the selected digit is driven. The displayed frame (data,
// dp_en, blank_lz) is captured only when the scan wraps from digit 3 to 0.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   clk_1K   in   scan square wave (sampled as data)
//   data     in   [15:0] four BCD digits, [15:12] = digit 3
//   dp_en    in   [3:0] decimal-point enables, bit i = digit i
//   blank_lz in   blank leading zeros when 1
//   an       out  [3:0] active-low anodes, bit i = digit i
//   seg      out  [6:0] active-low segments {g,f,e,d,c,b,a}
//   dp       out  active-low decimal point
module seg_scan #(
    parameter logic [3:0] BLANK_CYC = 4'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_1K,
    input  logic [15:0] data,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic        s1_q, s2_q, s3_q;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  blank_cnt_q, blank_cnt_d;
    logic [15:0] frame_q, frame_d;
    logic [3:0]  dp_frame_q, dp_frame_d;
    logic        blz_q, blz_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic        tick;
    logic        show;
    logic [3:0]  digit;
    logic        lz;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0:    r = 7'b1000000;
            4'd1:    r = 7'b1111001;
            4'd2:    r = 7'b0100100;
            4'd3:    r = 7'b0110000;
            4'd4:    r = 7'b0011001;
            4'd5:    r = 7'b0010010;
            4'd6:    r = 7'b0000010;
            4'd7:    r = 7'b1111000;
            4'd8:    r = 7'b0000000;
            4'd9:    r = 7'b0010000;
            default: r = 7'b0111111; // non-BCD shows a dash
        endcase
        return r;
    endfunction

    assign tick = s2_q & ~s3_q;

    always_comb begin
        idx_d       = idx_q;
        blank_cnt_d = blank_cnt_q;
        frame_d     = frame_q;
        dp_frame_d  = dp_frame_q;
        blz_d       = blz_q;
        an_d        = an_q;
        seg_d       = seg_q;
        dp_d        = dp_q;
        show        = 1'b0;

        if (tick) begin
            // A tick always wins, even mid-blank: advance and restart dead time.
            idx_d       = idx_q + 2'd1;
            blank_cnt_d = BLANK_CYC;
            if (idx_q == 2'd3) begin
                frame_d    = data;
                dp_frame_d = dp_en;
                blz_d      = blank_lz;
            end
            if (BLANK_CYC == 4'd0) begin
                show = 1'b1;
            end else begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
                dp_d  = 1'b1;
            end
        end else if (blank_cnt_q != 4'd0) begin
            blank_cnt_d = blank_cnt_q - 4'd1;
            if (blank_cnt_q == 4'd1) show = 1'b1;
        end

        // Display values are derived from the next-state frame/index so the
        // zero-dead-time case shows the freshly latched frame on the tick edge.
        case (idx_d)
            2'd3:    begin digit = frame_d[15:12]; lz = (frame_d[15:12] == 4'd0); end
            2'd2:    begin digit = frame_d[11:8];  lz = (frame_d[15:8]  == 8'd0); end
            2'd1:    begin digit = frame_d[7:4];   lz = (frame_d[15:4]  == 12'd0); end
            default: begin digit = frame_d[3:0];   lz = 1'b0; end
        endcase

        if (show) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = (blz_d && lz) ? 7'b1111111 : decode(digit);
            dp_d  = ~dp_frame_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            idx_q       <= 2'd3;
            blank_cnt_q <= 4'd0;
            frame_q     <= 16'd0;
            dp_frame_q  <= 4'd0;
            blz_q       <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
        end else begin
            s1_q        <= clk_1K;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            idx_q       <= idx_d;
            blank_cnt_q <= blank_cnt_d;
            frame_q     <= frame_d;
            dp_frame_q  <= dp_frame_d;
            blz_q       <= blz_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed testbench for seg_scan. A default instance (BLANK_CYC=2) is the
// main subject; a second instance with BLANK_CYC=0 shares all inputs and
// stays in step with it, so it is checked on the tick edge itself.
module tb_seg_scan;

    logic        clk;
    logic        reset;
    logic        clk_1K;
    logic [15:0] data;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic [3:0]  an,  an0;
    logic [6:0]  seg, seg0;
    logic        dp,  dp0;

    int tests_run;
    int tests_failed;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S7 = 7'b1111000,
                           S8 = 7'b0000000, SDASH = 7'b0111111, SOFF = 7'b1111111;

    seg_scan dut (
        .clk(clk), .reset(reset), .clk_1K(clk_1K), .data(data), .dp_en(dp_en),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp)
    );

    seg_scan #(.BLANK_CYC(4'd0)) dut0 (
        .clk(clk), .reset(reset), .clk_1K(clk_1K), .data(data), .dp_en(dp_en),
        .blank_lz(blank_lz), .an(an0), .seg(seg0), .dp(dp0)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one clk_1K low->high transition; returns #1 after the tick edge.
    task automatic do_tick();
        @(negedge clk) clk_1K = 1'b0;
        repeat (3) @(negedge clk);
        clk_1K = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clk_1K = 1'b0; data = 16'h0; dp_en = 4'h0; blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({an, seg, dp} !== {4'b1111, SOFF, 1'b1}) begin
                tests_failed++;
                $display("FAIL reset_idle cyc %0d: got an=%b seg=%b dp=%b want 1111 1111111 1", i, an, seg, dp);
            end
        end
    endtask

    // One digit step: tick, check dead time, check the shown digit.
    task automatic step(input string name, input logic [3:0] exp_an,
                        input logic [6:0] exp_seg, input logic exp_dp);
        do_tick();
        tests_run++;
        if (an !== 4'b1111) begin
            tests_failed++;
            $display("FAIL %s blank0: got an=%b want 1111", name, an);
        end
        tests_run++;
        if ({an0, seg0, dp0} !== {exp_an, exp_seg, exp_dp}) begin
            tests_failed++;
            $display("FAIL %s zero_blank: got an=%b seg=%b dp=%b want %b %b %b",
                     name, an0, seg0, dp0, exp_an, exp_seg, exp_dp);
        end
        wait_cycles(1);
        tests_run++;
        if (an !== 4'b1111) begin
            tests_failed++;
            $display("FAIL %s blank1: got an=%b want 1111", name, an);
        end
        wait_cycles(1);
        tests_run++;
        if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
            tests_failed++;
            $display("FAIL %s show: got an=%b seg=%b dp=%b want %b %b %b",
                     name, an, seg, dp, exp_an, exp_seg, exp_dp);
        end
    endtask

    task automatic test_basic_1234();
        data = 16'h1234; dp_en = 4'b0100; blank_lz = 1'b0;
        step("d0_4", 4'b1110, S4, 1'b1);
        step("d1_3", 4'b1101, S3, 1'b1);
        step("d2_2", 4'b1011, S2, 1'b0);
        step("d3_1", 4'b0111, S1, 1'b1);
        // clk_1K stays high: no further ticks, digit 3 must hold.
        wait_cycles(20);
        tests_run++;
        if ({an, seg, dp} !== {4'b0111, S1, 1'b1}) begin
            tests_failed++;
            $display("FAIL freeze: got an=%b seg=%b dp=%b want 0111 %b 1", an, seg, dp, S1);
        end
    endtask

    task automatic test_leading_zero();
        data = 16'h0070; dp_en = 4'b0000; blank_lz = 1'b1;
        step("lz1_d0", 4'b1110, S0, 1'b1);
        step("lz1_d1", 4'b1101, S7, 1'b1);
        step("lz1_d2", 4'b1011, SOFF, 1'b1);
        step("lz1_d3", 4'b0111, SOFF, 1'b1);
        blank_lz = 1'b0;
        step("lz0_d0", 4'b1110, S0, 1'b1);
        step("lz0_d1", 4'b1101, S7, 1'b1);
        step("lz0_d2", 4'b1011, S0, 1'b1);
        step("lz0_d3", 4'b0111, S0, 1'b1);
    endtask

    task automatic test_dash();
        data = 16'hA00F; dp_en = 4'b1001; blank_lz = 1'b0;
        step("dash_d0", 4'b1110, SDASH, 1'b0);
        step("dash_d1", 4'b1101, S0, 1'b1);
        step("dash_d2", 4'b1011, S0, 1'b1);
        step("dash_d3", 4'b0111, SDASH, 1'b0);
    endtask

    task automatic test_frame_latch();
        data = 16'h1111; dp_en = 4'b0000; blank_lz = 1'b0;
        step("fr_d0", 4'b1110, S1, 1'b1);
        step("fr_d1", 4'b1101, S1, 1'b1);
        data = 16'h2222;
        step("fr_d2", 4'b1011, S1, 1'b1);
        step("fr_d3", 4'b0111, S1, 1'b1);
        step("fr_next_d0", 4'b1110, S2, 1'b1);
    endtask

    task automatic test_reset_on_tick();
        data = 16'h5678; dp_en = 4'b0001;
        @(negedge clk) clk_1K = 1'b0;
        repeat (3) @(negedge clk);
        clk_1K = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;   // lands on the tick edge
        @(posedge clk); #1;
        tests_run++;
        if ({an, seg, dp, an0, seg0, dp0} !== {4'b1111, SOFF, 1'b1, 4'b1111, SOFF, 1'b1}) begin
            tests_failed++;
            $display("FAIL rst_tick: got an=%b seg=%b dp=%b an0=%b want 1111 1111111 1", an, seg, dp, an0);
        end
        @(negedge clk) begin reset = 1'b0; clk_1K = 1'b0; end
        step("rst_tick_d0", 4'b1110, S8, 1'b0);
    endtask

    task automatic test_reset_mid_blank();
        data = 16'h0003; dp_en = 4'b0000;
        do_tick();
        @(posedge clk);                   // blank_cnt now 1
        @(negedge clk) begin reset = 1'b1; clk_1K = 1'b0; end
        @(posedge clk); #1;
        tests_run++;
        if ({an, seg, dp} !== {4'b1111, SOFF, 1'b1}) begin
            tests_failed++;
            $display("FAIL rst_blank: got an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
        end
        @(negedge clk) reset = 1'b0;
        wait_cycles(6);
        tests_run++;
        if ({an, seg, dp} !== {4'b1111, SOFF, 1'b1}) begin
            tests_failed++;
            $display("FAIL rst_blank_after: got an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
        end
        step("rst_blank_d0", 4'b1110, S3, 1'b1);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic_1234();
        test_leading_zero();
        test_dash();
        test_frame_latch();
        test_reset_on_tick();
        test_reset_mid_blank();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter BLANK_CYC, default 4'd2: number of clk cycles all anodes are held off after each digit change (ghosting dead time); legal range 0-15.
REQ-002 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clk_1K  input  1  slow scan square wave from the clock divider, treated as data, not as a clock.
REQ-005 data  input  16  four BCD digits; data[15:12] is the most significant digit (digit 3), data[3:0] is digit 0.
REQ-006 dp_en  input  4  decimal-point enables; bit i belongs to digit i.
REQ-007 blank_lz  input  1  when 1, leading zeros are blanked.
REQ-008 an  output  4  active-low digit anodes; bit i selects digit i.
REQ-009 seg  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-010 dp  output  1  active-low decimal point.

Function
REQ-011 clk_1K shall pass through a three-stage register chain s1->s2->s3; tick = s2 & ~s3; all other behaviour is driven only by tick.
REQ-012 Digit index idx (2 bits) shall advance by one on each clk edge where tick=1, wrapping 3->0.
REQ-013 On the tick edge where idx wraps 3->0, data and dp_en shall be latched into frame and dp_frame; changes on data between wraps shall not be displayed.
REQ-014 On every tick edge, an shall go to 4'b1111 and blank_cnt shall load BLANK_CYC.
REQ-015 While blank_cnt != 0, blank_cnt shall decrement once per cycle and an shall stay at 4'b1111.
REQ-016 With BLANK_CYC = 0, an, seg and dp shall present the new digit on the tick edge itself.
REQ-017 On the edge where blank_cnt goes 1->0, an shall drive only bit idx low, and seg/dp shall show frame digit idx; the outputs are registered and stay stable until the next tick.
REQ-018 A tick arriving while blank_cnt != 0 shall restart the sequence: idx advances and blank_cnt reloads.
REQ-019 Decode: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000, and any value 10-15 shall decode to a dash, 7'b0111111.
REQ-020 Leading-zero blanking, when the latched blank_lz = 1, drives seg = 7'b1111111:
- digit 3 when it is 0;
- digit 2 when digits 3 and 2 are 0;
- digit 1 when digits 3, 2 and 1 are 0;
- digit 0 is never blanked.
REQ-021 blank_lz shall be latched with frame at the 3->0 wrap.
REQ-022 dp shall be ~dp_frame[idx], including on blanked digits.
REQ-023 If clk_1K stops toggling, scanning shall freeze on the current digit with the outputs held.

Reset
REQ-024 While reset=1 at a clk edge, the following shall take these values, and reset shall take priority over a simultaneous tick:
- s1, s2, s3 = 0;
- idx = 2'd3;
- blank_cnt = 0;
- frame = 0, dp_frame = 0, latched blank_lz = 0;
- an = 4'b1111, seg = 7'b1111111, dp = 1.
REQ-025 After reset, the first tick shall wrap idx to 0, latch the frame, and begin display at digit 0.
REQ-026 Reset asserted mid-blank or mid-frame shall abort the blank and discard the frame, with no partial output after release.

Verification
REQ-027 Reset, hold clk_1K=0 for 100 cycles -> an=1111, seg=1111111 and dp=1 throughout.
REQ-028 BLANK_CYC=2, data=16'h1234, dp_en=4'b0100, blank_lz=0, toggle clk_1K -> digit 0 shows seg=0011001 and an=1110 exactly 2 cycles after the tick edge; then digit 1 shows 0110000; digit 2 shows 0100100 with dp=0; digit 3 shows 1111001.
REQ-029 data=16'h0070 with blank_lz=1 -> digits 3 and 2 give seg=1111111, digit 1 gives 1111000, digit 0 gives 1000000; with blank_lz=0, digits 3 and 2 give 1000000.
REQ-030 data=16'hA00F -> digits 3 and 0 show the dash 0111111.
REQ-031 Change data from 16'h1111 to 16'h2222 while digit 1 is being shown -> digits 2 and 3 of that frame still show 1; the next frame shows 2 from digit 0.
REQ-032 Assert reset on the same edge as a tick, and separately during blank_cnt=1 -> outputs go to their reset values on that edge, and the next tick after release shows digit 0.
